tdm_demux8: RTL and testbench

//   Receive end of the 8:1 serial multiplexer. Takes the single-bit TDM stream Y (one channel
//   per slot, slot k = input Ik) and rebuilds the 8 channels into a registered parallel word.

---
 rtl/tdm_pkg.sv | 11 +
 rtl/tdm_slot_counter.sv | 35 +++
 rtl/tdm_demux8.sv | 148 ++++++++++++++
 tb/tb_tdm_demux8.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and FSM encoding for the TDM receive path.
package tdm_pkg;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;
    localparam int MISS_MAX = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM frame: increments per consumed slot, wraps 7->0,
// can be reloaded to 1 at a frame start or cleared when lock is lost.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [SEL_W-1:0] s,
    output logic             last
);

    logic [SEL_W-1:0] s_r;

    // Slot register: clear beats reload, reload beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r <= SEL_W'(0);
        end else if (clr) begin
            s_r <= SEL_W'(0);
        end else if (load) begin
            s_r <= SEL_W'(1);
        end else if (inc) begin
            s_r <= s_r + SEL_W'(1);
        end else begin
            s_r <= s_r;
        end
    end

    assign s    = s_r;
    assign last = (s_r == SEL_W'(CHANNELS - 1));

endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM demultiplexer: frames the serial stream on FS, rebuilds the parallel word,
// and reports lock and sticky sync errors.
module tdm_demux8 #(
    parameter int MISS_MAX = tdm_pkg::MISS_MAX
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Y,
    input  logic                     FS,
    input  logic                     EN,
    output logic [tdm_pkg::SEL_W-1:0] S,
    output logic [7:0]               O,
    output logic                     VLD,
    output logic                     LOCK,
    output logic                     ERR
);
    import tdm_pkg::*;

    localparam int MISS_W = $clog2(MISS_MAX + 1);

    state_t             state_r, state_next_s;
    logic [SEL_W-1:0]   slot_s;
    logic               last_s;
    logic               cnt_clr_s, cnt_load_s, cnt_inc_s;
    logic               shadow_we_s;
    logic [SEL_W-1:0]   shadow_idx_s;
    logic               frame_done_s;
    logic               err_set_s;
    logic [MISS_W-1:0]  miss_r, miss_next_s, miss_plus_s;
    logic [6:0]         shadow_r;
    logic [7:0]         o_r;
    logic               vld_r, lock_r, err_r;

    tdm_slot_counter u_slot (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr_s),
        .load (cnt_load_s),
        .inc  (cnt_inc_s),
        .s    (slot_s),
        .last (last_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and slot control; any FS off slot 0 (slot 7 included) resyncs before completion.
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_inc_s    = 1'b0;
        shadow_we_s  = 1'b0;
        shadow_idx_s = slot_s;
        frame_done_s = 1'b0;
        err_set_s    = 1'b0;
        miss_next_s  = miss_r;
        miss_plus_s  = miss_r + MISS_W'(1);
        if (EN) begin
            case (state_r)
                HUNT: begin
                    if (FS) begin
                        shadow_we_s  = 1'b1;
                        shadow_idx_s = SEL_W'(0);
                        cnt_load_s   = 1'b1;
                        miss_next_s  = MISS_W'(0);
                        state_next_s = LOCKED;
                    end else begin
                        state_next_s = HUNT;
                    end
                end
                LOCKED: begin
                    if (FS) begin
                        err_set_s    = (slot_s != SEL_W'(0));
                        shadow_we_s  = 1'b1;
                        shadow_idx_s = SEL_W'(0);
                        cnt_load_s   = 1'b1;
                        miss_next_s  = MISS_W'(0);
                    end else if (slot_s == SEL_W'(0)) begin
                        if (miss_plus_s >= MISS_W'(MISS_MAX)) begin
                            err_set_s    = 1'b1;
                            cnt_clr_s    = 1'b1;
                            miss_next_s  = MISS_W'(0);
                            state_next_s = HUNT;
                        end else begin
                            shadow_we_s  = 1'b1;
                            shadow_idx_s = SEL_W'(0);
                            cnt_load_s   = 1'b1;
                            miss_next_s  = miss_plus_s;
                        end
                    end else if (last_s) begin
                        frame_done_s = 1'b1;
                        cnt_inc_s    = 1'b1;
                    end else begin
                        shadow_we_s  = 1'b1;
                        cnt_inc_s    = 1'b1;
                    end
                end
                default: begin
                    state_next_s = HUNT;
                    cnt_clr_s    = 1'b1;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Datapath registers: shadow capture, output word, miss count, flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_r <= 7'd0;
            o_r      <= 8'd0;
            vld_r    <= 1'b0;
            lock_r   <= 1'b0;
            err_r    <= 1'b0;
            miss_r   <= MISS_W'(0);
        end else begin
            if (shadow_we_s) begin
                shadow_r[shadow_idx_s] <= Y;
            end else begin
                shadow_r <= shadow_r;
            end
            if (frame_done_s) begin
                o_r <= {Y, shadow_r};
            end else begin
                o_r <= o_r;
            end
            vld_r  <= frame_done_s;
            lock_r <= (state_next_s == LOCKED);
            err_r  <= err_r | err_set_s;
            miss_r <= miss_next_s;
        end
    end

    assign S    = slot_s;
    assign O    = o_r;
    assign VLD  = vld_r;
    assign LOCK = lock_r;
    assign ERR  = err_r;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed + randomized bench for tdm_demux8 against a slot-level reference model.
module tb_tdm_demux8;
    logic       CLK = 1'b0;
    logic       RST, Y, FS, EN;
    logic [2:0] S;
    logic [7:0] O;
    logic       VLD, LOCK, ERR;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int vld_last = 0;
    int vld_gap = 0;

    // reference model state, in terms of frame slots
    bit       m_lock;
    int       m_s;
    bit [7:0] m_buf;
    int       m_miss;
    bit [7:0] m_o;
    bit       m_vld, m_err;

    tdm_demux8 dut (
        .CLK(CLK), .RST(RST), .Y(Y), .FS(FS), .EN(EN),
        .S(S), .O(O), .VLD(VLD), .LOCK(LOCK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0; m_s = 0; m_buf = 8'd0; m_miss = 0;
        m_o = 8'd0; m_vld = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit y, input bit fs, input bit en);
        m_vld = 1'b0;
        if (en) begin
            if (!m_lock) begin
                if (fs) begin
                    m_buf[0] = y; m_s = 1; m_miss = 0; m_lock = 1'b1;
                end
            end else if (fs) begin
                if (m_s != 0) m_err = 1'b1;
                m_buf[0] = y; m_s = 1; m_miss = 0;
            end else if (m_s == 0) begin
                m_miss = m_miss + 1;
                if (m_miss >= 2) begin
                    m_err = 1'b1; m_lock = 1'b0; m_s = 0; m_miss = 0;
                end else begin
                    m_buf[0] = y; m_s = 1;
                end
            end else begin
                m_buf[m_s] = y;
                if (m_s == 7) begin
                    m_o = m_buf; m_vld = 1'b1; m_s = 0;
                end else begin
                    m_s = m_s + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [2:0] es;
        es = m_s[2:0];
        chk("S", S, es);
        chk("O", O, m_o);
        chk("VLD", VLD, m_vld);
        chk("LOCK", LOCK, m_lock);
        chk("ERR", ERR, m_err);
        if (VLD === 1'b1) begin
            vld_gap  = cyc_n - vld_last;
            vld_last = cyc_n;
        end
    endtask

    task automatic cyc(input bit y, input bit fs, input bit en);
        Y = y; FS = fs; EN = en;
        @(posedge CLK);
        cyc_n++;
        model_step(y, fs, en);
        #1;
        check_all();
    endtask

    task automatic send_frame(input bit [7:0] b, input bit fs0);
        for (int k = 0; k < 8; k++) cyc(b[k], (k == 0) ? fs0 : 1'b0, 1'b1);
    endtask

    initial begin
        bit [7:0] b;
        bit       y0;
        RST = 1'b1; Y = 1'b0; FS = 1'b0; EN = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        #1 RST = 1'b0;

        // 1: known frame
        send_frame(8'b0100_1101, 1'b1);
        chk("t1_o", O, 8'b0100_1101);
        chk("t1_vld", VLD, 1'b1);
        chk("t1_lock", LOCK, 1'b1);
        chk("t1_err", ERR, 1'b0);

        // 2: back-to-back random frames
        for (int f = 0; f < 8; f++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            chk("t2_o", O, b);
            chk("t2_vld", VLD, 1'b1);
            chk("t2_gap", vld_gap, 8);
        end
        chk("t2_err", ERR, 1'b0);

        // 3: EN at 50% duty, FS high on idle cycles must be ignored
        b = 8'b0100_1101;
        for (int k = 0; k < 8; k++) begin
            cyc(b[k], k == 0, 1'b1);
            if (k < 7) cyc(1'($urandom), 1'b1, 1'b0);
        end
        chk("t3_o", O, 8'b0100_1101);
        chk("t3_vld", VLD, 1'b1);
        chk("t3_err", ERR, 1'b0);

        // 4: early sync at slot 4
        for (int k = 0; k < 4; k++) cyc(1'($urandom), k == 0, 1'b1);
        chk("t4_s4", S, 3'd4);
        y0 = 1'($urandom);
        cyc(y0, 1'b1, 1'b1);
        chk("t4_err", ERR, 1'b1);
        chk("t4_lock", LOCK, 1'b1);
        chk("t4_vld", VLD, 1'b0);
        b = 8'($urandom);
        b[0] = y0;
        for (int k = 1; k < 8; k++) cyc(b[k], 1'b0, 1'b1);
        chk("t4_o", O, b);
        chk("t4_vld2", VLD, 1'b1);

        // 5: two missed syncs drop lock
        send_frame(8'($urandom), 1'b0);
        chk("t5_lock1", LOCK, 1'b1);
        cyc(1'($urandom), 1'b0, 1'b1);
        chk("t5_lock2", LOCK, 1'b0);
        chk("t5_s", S, 3'd0);
        for (int k = 0; k < 5; k++) cyc(1'($urandom), 1'b0, 1'b1);
        chk("t5_hunt", LOCK, 1'b0);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        chk("t5_o", O, b);

        // 6: async reset mid-frame
        for (int k = 0; k < 5; k++) cyc(1'($urandom), k == 0, 1'b1);
        chk("t6_s5", S, 3'd5);
        #3 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_o", O, 8'd0);
        chk("t6_lock", LOCK, 1'b0);
        @(posedge CLK);
        #1;
        check_all();
        #1 RST = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'($urandom), 1'b0, 1'b1);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        chk("t6_o2", O, b);
        chk("t6_vld", VLD, 1'b1);

        // randomized soak with sparse EN and occasional stray FS
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom), ($urandom_range(0, 15) == 0) || (m_s == 0 && $urandom_range(0, 7) != 0),
                $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
